vector_row_loader: RTL and testbench

- Producer side of the row-sum datapath. Receives a serial stream of signed weight beats over a valid/ready handshake.
- Packs the beats into one full `vector_size`-word row, pairs it with the row's spin bit, and presents the packed row plus spin as a held, valid/ready-qualified output. The output drives the reduce-adder's inVector/current_spin inputs.
- Double-buffered (fill buffer + output buffer), so a new row can load while the previous row waits on the consumer.

---
 rtl/vector_row_loader.sv | 140 ++++++++++++++
 tb/tb_vector_row_loader.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/vector_row_loader.sv
// Packs serial weight beats into a full row and hands it to the reduce-adder.
// A fill buffer and an output buffer let the next row load while the consumer stalls.
//   state | meaning
//   IDLE  | no partial row; next accepted beat is beat 0
//   FILL  | partial row in progress
//   FULL  | fill buffer holds a complete row waiting for the output slot
module vector_row_loader #(
    parameter int word_size      = 4,
    parameter int vector_size    = 32,
    parameter int words_per_beat = 4,
    parameter int cnt_size       = 16
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [words_per_beat*word_size-1:0] in_data,
    input  logic                              in_last,
    input  logic                              in_spin,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [vector_size*word_size-1:0]  out_vector,
    output logic                              out_spin,
    output logic                              err_frame,
    output logic [cnt_size-1:0]               row_count
);

    localparam int BEATS  = vector_size / words_per_beat;
    localparam int BEAT_W = words_per_beat * word_size;
    localparam int VEC_W  = vector_size * word_size;
    localparam int BCW    = (BEATS > 1) ? $clog2(BEATS) : 1;

    typedef enum logic [1:0] {IDLE, FILL, FULL} state_t;

    state_t             state_q, state_d;
    logic [BCW-1:0]     beat_cnt_q, beat_cnt_d;
    logic [VEC_W-1:0]   fill_q, fill_d;
    logic               fill_spin_q, fill_spin_d;
    logic [VEC_W-1:0]   out_vector_q, out_vector_d;
    logic               out_spin_q, out_spin_d;
    logic               out_valid_q, out_valid_d;
    logic               err_frame_q, err_frame_d;
    logic [cnt_size-1:0] row_count_q, row_count_d;

    logic accept, handoff, last_beat, slot_free;

    assign in_ready  = ~rst & (state_q != FULL);
    assign accept    = in_valid & in_ready;
    assign handoff   = out_valid_q & out_ready;
    assign last_beat = (beat_cnt_q == BCW'(BEATS - 1));
    assign slot_free = ~out_valid_q | out_ready;

    always_comb begin
        state_d      = state_q;
        beat_cnt_d   = beat_cnt_q;
        fill_d       = fill_q;
        fill_spin_d  = fill_spin_q;
        out_vector_d = out_vector_q;
        out_spin_d   = out_spin_q;
        out_valid_d  = out_valid_q;
        err_frame_d  = 1'b0;
        row_count_d  = row_count_q;

        // fill_d/fill_spin_d include the current beat so a completing row can bypass straight to the output
        if (accept) begin
            for (int b = 0; b < BEATS; b++) begin
                if (beat_cnt_q == BCW'(b)) fill_d[b*BEAT_W +: BEAT_W] = in_data;
            end
            if (beat_cnt_q == '0) fill_spin_d = in_spin;
        end

        if (handoff) begin
            out_valid_d = 1'b0;
            row_count_d = row_count_q + cnt_size'(1);
        end

        if (state_q == FULL && handoff) begin
            out_vector_d = fill_q;
            out_spin_d   = fill_spin_q;
            out_valid_d  = 1'b1;
            state_d      = IDLE;
        end

        if (accept) begin
            if (last_beat) begin
                beat_cnt_d  = '0;
                err_frame_d = ~in_last;
                if (slot_free) begin
                    out_vector_d = fill_d;
                    out_spin_d   = fill_spin_d;
                    out_valid_d  = 1'b1;
                    state_d      = IDLE;
                end else begin
                    state_d = FULL;
                end
            end else if (in_last) begin
                beat_cnt_d  = '0;
                err_frame_d = 1'b1;
                state_d     = IDLE;
            end else begin
                beat_cnt_d = beat_cnt_q + BCW'(1);
                state_d    = FILL;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            beat_cnt_q   <= '0;
            fill_spin_q  <= 1'b0;
            out_vector_q <= '0;
            out_spin_q   <= 1'b0;
            out_valid_q  <= 1'b0;
            err_frame_q  <= 1'b0;
            row_count_q  <= '0;
        end else begin
            state_q      <= state_d;
            beat_cnt_q   <= beat_cnt_d;
            fill_spin_q  <= fill_spin_d;
            out_vector_q <= out_vector_d;
            out_spin_q   <= out_spin_d;
            out_valid_q  <= out_valid_d;
            err_frame_q  <= err_frame_d;
            row_count_q  <= row_count_d;
        end
    end

    // Fill contents are meaningless until a row completes, so they carry no reset.
    always_ff @(posedge clk) begin
        fill_q <= fill_d;
    end

    assign out_valid  = out_valid_q;
    assign out_vector = out_vector_q;
    assign out_spin   = out_spin_q;
    assign err_frame  = err_frame_q;
    assign row_count  = row_count_q;

endmodule

// File: tb/tb_vector_row_loader.sv
// Directed bench for vector_row_loader with 8 words of 4 bits, 2 words per beat.
module tb_vector_row_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic        in_last;
    logic        in_spin;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_vector;
    logic        out_spin;
    logic        err_frame;
    logic [15:0] row_count;

    int errors = 0;
    int checks = 0;

    vector_row_loader #(
        .word_size(4), .vector_size(8), .words_per_beat(2), .cnt_size(16)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_last(in_last), .in_spin(in_spin),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_vector(out_vector), .out_spin(out_spin),
        .err_frame(err_frame), .row_count(row_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // streaming monitor, sampled on the falling edge
    logic mon_on = 1'b0;
    int   hand_cnt = 0;
    int   ir_low = 0;
    int   cyc = 0;
    int   hand_cyc[3];

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (mon_on && out_valid && out_ready) begin
            if (hand_cnt < 3) hand_cyc[hand_cnt] = cyc;
            hand_cnt = hand_cnt + 1;
        end
        if (mon_on && in_valid && !in_ready) ir_low = ir_low + 1;
    end

    task automatic do_reset();
        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; in_spin = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // Returns 1 time unit after the edge that accepted the beat.
    task automatic send_beat(input logic [7:0] d, input logic last, input logic spin);
        int n;
        in_valid = 1'b1; in_data = d; in_last = last; in_spin = spin;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("beat_timeout", 64'd0, 64'd1);
        @(posedge clk); #1;
    endtask

    // Spin is driven inverted on beats 1..3 so only beat 0 may be captured.
    task automatic send_row(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                            input logic [7:0] b3, input logic last, input logic spin, input logic stop);
        send_beat(b0, 1'b0, spin);
        send_beat(b1, 1'b0, ~spin);
        send_beat(b2, 1'b0, ~spin);
        send_beat(b3, last, ~spin);
        if (stop) begin
            in_valid = 1'b0; in_last = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        out_ready = 1'b1;
        do_reset();
        @(negedge clk);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_vector", out_vector, 32'h0);
        check("rst_row_count", row_count, 16'd0);
        check("rst_err", err_frame, 1'b0);
        check("rst_in_ready", in_ready, 1'b1);
        @(posedge clk); #1;

        // basic row
        send_row(8'h21, 8'h43, 8'h65, 8'h87, 1'b1, 1'b1, 1'b1);
        @(negedge clk);
        check("basic_valid", out_valid, 1'b1);
        check("basic_vector", out_vector, 32'h87654321);
        check("basic_spin", out_spin, 1'b1);
        check("basic_err", err_frame, 1'b0);
        @(negedge clk);
        check("basic_count", row_count, 16'd1);
        check("basic_drop", out_valid, 1'b0);
        @(posedge clk); #1;

        // backpressure
        do_reset();
        out_ready = 1'b0;
        send_row(8'h11, 8'h11, 8'h11, 8'h11, 1'b1, 1'b0, 1'b1);
        send_row(8'h22, 8'h22, 8'h22, 8'h22, 1'b1, 1'b1, 1'b1);
        @(negedge clk);
        check("bp_in_ready", in_ready, 1'b0);
        check("bp_hold_a", out_vector, 32'h11111111);
        check("bp_hold_spin", out_spin, 1'b0);
        @(posedge clk); #1;
        in_valid = 1'b1; in_data = 8'h33;
        @(negedge clk);
        check("bp_blocked", in_ready, 1'b0);
        @(negedge clk);
        check("bp_still_a", out_vector, 32'h11111111);
        #1 in_valid = 1'b0;
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        @(negedge clk);
        check("bp_vector_b", out_vector, 32'h22222222);
        check("bp_spin_b", out_spin, 1'b1);
        check("bp_valid_b", out_valid, 1'b1);
        check("bp_in_ready_back", in_ready, 1'b1);
        check("bp_count", row_count, 16'd1);
        @(posedge clk); #1;

        // back-to-back streaming
        do_reset();
        out_ready = 1'b1;
        mon_on = 1'b1;
        send_row(8'h01, 8'h02, 8'h03, 8'h04, 1'b1, 1'b0, 1'b0);
        send_row(8'h05, 8'h06, 8'h07, 8'h08, 1'b1, 1'b1, 1'b0);
        send_row(8'h09, 8'h0A, 8'h0B, 8'h0C, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        check("stream_last_vector", out_vector, 32'h0C0B0A09);
        @(negedge clk);
        @(negedge clk);
        mon_on = 1'b0;
        check("stream_in_ready_low", ir_low, 0);
        check("stream_handoffs", hand_cnt, 3);
        check("stream_gap1", hand_cyc[1] - hand_cyc[0], 4);
        check("stream_gap2", hand_cyc[2] - hand_cyc[1], 4);
        check("stream_count", row_count, 16'd3);
        @(posedge clk); #1;

        // early in_last
        do_reset();
        send_beat(8'hAA, 1'b0, 1'b1);
        send_beat(8'hBB, 1'b1, 1'b1);
        in_valid = 1'b0; in_last = 1'b0;
        @(negedge clk);
        check("early_err", err_frame, 1'b1);
        check("early_no_valid", out_valid, 1'b0);
        @(negedge clk);
        check("early_err_once", err_frame, 1'b0);
        @(posedge clk); #1;
        send_row(8'h21, 8'h43, 8'h65, 8'h87, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        check("early_recover_valid", out_valid, 1'b1);
        check("early_recover_vector", out_vector, 32'h87654321);
        check("early_recover_spin", out_spin, 1'b0);
        check("early_recover_err", err_frame, 1'b0);
        @(posedge clk); #1;

        // missing in_last
        do_reset();
        send_row(8'h10, 8'h32, 8'h54, 8'h76, 1'b0, 1'b1, 1'b1);
        @(negedge clk);
        check("miss_valid", out_valid, 1'b1);
        check("miss_vector", out_vector, 32'h76543210);
        check("miss_err", err_frame, 1'b1);
        @(negedge clk);
        check("miss_err_once", err_frame, 1'b0);
        @(posedge clk); #1;

        // reset mid-row with a held output
        do_reset();
        send_row(8'h44, 8'h44, 8'h44, 8'h44, 1'b1, 1'b0, 1'b1);
        @(posedge clk); #1;
        out_ready = 1'b0;
        send_row(8'h55, 8'h55, 8'h55, 8'h55, 1'b1, 1'b1, 1'b1);
        send_beat(8'h99, 1'b0, 1'b1);
        send_beat(8'h99, 1'b0, 1'b1);
        in_valid = 1'b0;
        @(negedge clk);
        check("mid_pre_count", row_count, 16'd1);
        check("mid_pre_valid", out_valid, 1'b1);
        #1 rst = 1'b1;
        @(negedge clk);
        check("mid_rst_in_ready", in_ready, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("mid_out_valid", out_valid, 1'b0);
        check("mid_count", row_count, 16'd0);
        check("mid_in_ready", in_ready, 1'b1);
        check("mid_err", err_frame, 1'b0);
        @(posedge clk); #1;
        send_row(8'h21, 8'h43, 8'h65, 8'h87, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        check("mid_new_vector", out_vector, 32'h87654321);
        check("mid_new_spin", out_spin, 1'b0);
        check("mid_new_valid", out_valid, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
